// File: rtl/vscale_wb_merge_pkg.sv
// Shared widths and types for the write-back merge stage and its result FIFO.
package vscale_wb_merge_pkg;

    localparam int XPR_LEN        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] wa;
        logic [XPR_LEN-1:0]        wd;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_MD   = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/vscale_wb_fifo.sv
// Small in-order sync FIFO for multiply/divide results, with occupancy count.
module vscale_wb_fifo
    import vscale_wb_merge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  push_data,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vscale_wb_merge.sv
// Merges pipeline write-backs and buffered mul/div results onto the regfile write port,
// tracking outstanding mul/div destinations in a busy scoreboard.
module vscale_wb_merge
    import vscale_wb_merge_pkg::*;
#(
    parameter int MD_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pipe_wen,
    input  logic [REG_ADDR_WIDTH-1:0]  pipe_wa,
    input  logic [XPR_LEN-1:0]         pipe_wd,
    input  logic                       md_issue,
    input  logic [REG_ADDR_WIDTH-1:0]  md_issue_wa,
    input  logic                       md_resp_valid,
    output logic                       md_resp_ready,
    input  logic [REG_ADDR_WIDTH-1:0]  md_resp_wa,
    input  logic [XPR_LEN-1:0]         md_resp_wd,
    input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       rf_wen,
    output logic [REG_ADDR_WIDTH-1:0]  rf_wa,
    output logic [XPR_LEN-1:0]         rf_wd,
    output logic [$clog2(MD_DEPTH):0]  md_pending,
    output logic                       err
);

    wb_entry_t              head;
    wb_entry_t              resp_entry;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    wb_sel_t                sel;
    logic [NUM_REGS-1:0]    busy;
    logic [NUM_REGS-1:0]    busy_next;
    logic                   err_set;

    assign resp_entry    = '{wa: md_resp_wa, wd: md_resp_wd};
    assign md_resp_ready = reset_n && !fifo_full;
    assign push          = md_resp_valid && md_resp_ready;

    vscale_wb_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (resp_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (md_pending)
    );

    always_comb begin
        sel = SEL_IDLE;
        if (pipe_wen)         sel = SEL_PIPE;
        else if (!fifo_empty) sel = SEL_MD;
    end

    assign pop = (sel == SEL_MD);

    always_comb begin
        rf_wen = 1'b0;
        rf_wa  = '0;
        rf_wd  = '0;
        case (sel)
            SEL_PIPE: begin
                rf_wen = reset_n;
                rf_wa  = pipe_wa;
                rf_wd  = pipe_wd;
            end
            SEL_MD: begin
                rf_wen = reset_n;
                rf_wa  = head.wa;
                rf_wd  = head.wd;
            end
            default: ;
        endcase
    end

    // Issue is applied after the pop clear so a re-issue to the retiring register wins.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.wa] = 1'b0;
        if (md_issue && (md_issue_wa != '0)) busy_next[md_issue_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

    assign err_set = (pipe_wen && (pipe_wa != '0) && busy[pipe_wa]) ||
                     (md_resp_valid && (md_resp_wa != '0) && !busy[md_resp_wa]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            if (err_set) err <= 1'b1;
        end
    end

endmodule
